// File: rtl/fp_addsub_pipe.sv
// ---- fp_addsub_pipe : 3-stage IEEE-754 add/sub, RNE rounding, flush-to-zero, valid/ready ----
// ---- rev 1.0 ----
`timescale 1ns/1ps
`default_nettype none

module fp_addsub_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   op,
  input  logic [EXP_W+MAN_W:0]   a,
  input  logic [EXP_W+MAN_W:0]   b,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   c,
  output logic [3:0]             flags
);

  localparam int W     = 1 + EXP_W + MAN_W;
  localparam int SIG_W = MAN_W + 4;
  localparam int LZC_W = $clog2(SIG_W + 1);
  localparam logic [W-2:0] INF_MAG = {{EXP_W{1'b1}}, {MAN_W{1'b0}}};
  localparam logic [W-1:0] QNAN    = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  function automatic logic [LZC_W-1:0] lzc_f(input logic [SIG_W-1:0] v);
    lzc_f = LZC_W'(SIG_W);
    for (int i = 0; i < SIG_W; i++) begin
      if (v[i]) lzc_f = LZC_W'(SIG_W - 1 - i);
    end
  endfunction

  logic w_ready1, w_ready2, w_ready3;
  logic s1_valid_q, s2_valid_q, out_valid_q;

  assign w_ready3 = !out_valid_q || out_ready;
  assign w_ready2 = !s2_valid_q  || w_ready3;
  assign w_ready1 = !s1_valid_q  || w_ready2;
  assign in_ready = w_ready1;

  // ---------------- stage 1: classify, swap, align ----------------
  logic             w_sa, w_sb, w_sx, w_sy, w_swap;
  logic [EXP_W-1:0] w_ea, w_eb, w_ex, w_ey, w_diff;
  logic [MAN_W-1:0] w_fa, w_fb, w_fx, w_fy;
  logic             w_a_zero, w_b_zero, w_a_nan, w_b_nan, w_a_snan, w_b_snan, w_a_inf, w_b_inf;
  logic [W-2:0]     w_ma, w_mb;
  logic [SIG_W-1:0] w_sigy, w_shifted, w_lost;
  logic [SIG_W-1:0] s1_sigx_d, s1_sigy_d;
  logic             s1_spec_d, s1_negz_d;
  logic [W-1:0]     s1_spec_res_d;
  logic [3:0]       s1_spec_flg_d;

  assign w_sa = a[W-1];
  assign w_sb = b[W-1] ^ op;
  assign w_ea = a[W-2:MAN_W];
  assign w_eb = b[W-2:MAN_W];
  assign w_fa = a[MAN_W-1:0];
  assign w_fb = b[MAN_W-1:0];

  assign w_a_zero = ~|w_ea;
  assign w_b_zero = ~|w_eb;
  assign w_a_nan  = (&w_ea) && (|w_fa);
  assign w_b_nan  = (&w_eb) && (|w_fb);
  assign w_a_snan = w_a_nan && !w_fa[MAN_W-1];
  assign w_b_snan = w_b_nan && !w_fb[MAN_W-1];
  assign w_a_inf  = (&w_ea) && !(|w_fa);
  assign w_b_inf  = (&w_eb) && !(|w_fb);

  // Denormals are flushed here so they order and align as zero.
  assign w_ma   = w_a_zero ? '0 : a[W-2:0];
  assign w_mb   = w_b_zero ? '0 : b[W-2:0];
  assign w_swap = w_mb > w_ma;
  assign w_sx   = w_swap ? w_sb : w_sa;
  assign w_sy   = w_swap ? w_sa : w_sb;
  assign w_ex   = w_swap ? w_mb[W-2:MAN_W]   : w_ma[W-2:MAN_W];
  assign w_ey   = w_swap ? w_ma[W-2:MAN_W]   : w_mb[W-2:MAN_W];
  assign w_fx   = w_swap ? w_mb[MAN_W-1:0]   : w_ma[MAN_W-1:0];
  assign w_fy   = w_swap ? w_ma[MAN_W-1:0]   : w_mb[MAN_W-1:0];
  assign w_diff = w_ex - w_ey;

  // Shifts of SIG_W-1 or more land the hidden bit on (or past) the sticky position.
  assign s1_sigx_d = {|w_ex, w_fx, 3'b000};
  assign w_sigy    = {|w_ey, w_fy, 3'b000};
  assign w_shifted = w_sigy >> w_diff;
  assign w_lost    = w_sigy & ~({SIG_W{1'b1}} << w_diff);
  assign s1_sigy_d = {w_shifted[SIG_W-1:1], w_shifted[0] | (|w_lost)};
  assign s1_negz_d = w_a_zero && w_b_zero && w_sa && w_sb;

  always_comb begin
    s1_spec_d     = 1'b0;
    s1_spec_res_d = '0;
    s1_spec_flg_d = 4'b0000;
    if (w_a_nan || w_b_nan) begin
      s1_spec_d     = 1'b1;
      s1_spec_res_d = QNAN;
      s1_spec_flg_d = {w_a_snan || w_b_snan, 3'b000};
    end else if (w_a_inf && w_b_inf && (w_sa != w_sb)) begin
      s1_spec_d     = 1'b1;
      s1_spec_res_d = QNAN;
      s1_spec_flg_d = 4'b1000;
    end else if (w_a_inf) begin
      s1_spec_d     = 1'b1;
      s1_spec_res_d = {w_sa, INF_MAG};
    end else if (w_b_inf) begin
      s1_spec_d     = 1'b1;
      s1_spec_res_d = {w_sb, INF_MAG};
    end
  end

  logic             s1_sign_q, s1_sub_q, s1_spec_q, s1_negz_q;
  logic [EXP_W-1:0] s1_exp_q;
  logic [SIG_W-1:0] s1_sigx_q, s1_sigy_q;
  logic [W-1:0]     s1_spec_res_q;
  logic [3:0]       s1_spec_flg_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid_q    <= 1'b0;
      s1_sign_q     <= 1'b0;
      s1_sub_q      <= 1'b0;
      s1_spec_q     <= 1'b0;
      s1_negz_q     <= 1'b0;
      s1_exp_q      <= '0;
      s1_sigx_q     <= '0;
      s1_sigy_q     <= '0;
      s1_spec_res_q <= '0;
      s1_spec_flg_q <= '0;
    end else begin
      if (w_ready1) s1_valid_q <= in_valid;
      if (w_ready1 && in_valid) begin
        s1_sign_q     <= w_sx;
        s1_sub_q      <= w_sx ^ w_sy;
        s1_spec_q     <= s1_spec_d;
        s1_negz_q     <= s1_negz_d;
        s1_exp_q      <= w_ex;
        s1_sigx_q     <= s1_sigx_d;
        s1_sigy_q     <= s1_sigy_d;
        s1_spec_res_q <= s1_spec_res_d;
        s1_spec_flg_q <= s1_spec_flg_d;
      end
    end
  end

  // ---------------- stage 2: significand add/sub ----------------
  logic [SIG_W:0]   s2_sum_d, s2_sum_q;
  logic             s2_sign_q, s2_spec_q, s2_negz_q;
  logic [EXP_W-1:0] s2_exp_q;
  logic [W-1:0]     s2_spec_res_q;
  logic [3:0]       s2_spec_flg_q;

  assign s2_sum_d = s1_sub_q ? ({1'b0, s1_sigx_q} - {1'b0, s1_sigy_q})
                             : ({1'b0, s1_sigx_q} + {1'b0, s1_sigy_q});

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s2_valid_q    <= 1'b0;
      s2_sum_q      <= '0;
      s2_sign_q     <= 1'b0;
      s2_spec_q     <= 1'b0;
      s2_negz_q     <= 1'b0;
      s2_exp_q      <= '0;
      s2_spec_res_q <= '0;
      s2_spec_flg_q <= '0;
    end else begin
      if (w_ready2) s2_valid_q <= s1_valid_q;
      if (w_ready2 && s1_valid_q) begin
        s2_sum_q      <= s2_sum_d;
        s2_sign_q     <= s1_sign_q;
        s2_spec_q     <= s1_spec_q;
        s2_negz_q     <= s1_negz_q;
        s2_exp_q      <= s1_exp_q;
        s2_spec_res_q <= s1_spec_res_q;
        s2_spec_flg_q <= s1_spec_flg_q;
      end
    end
  end

  // ---------------- stage 3: normalise, round, pack ----------------
  logic [LZC_W-1:0] w_lzc;
  logic [SIG_W-1:0] w_m;
  logic [EXP_W+1:0] w_e_norm, w_e_rnd;
  logic [MAN_W+1:0] w_rnd;
  logic [MAN_W-1:0] w_frac;
  logic             w_inexact, w_rup;
  logic [W-1:0]     c_d;
  logic [3:0]       flags_d;

  assign w_lzc = lzc_f(s2_sum_q[SIG_W-1:0]);

  always_comb begin
    if (s2_sum_q[SIG_W]) begin
      w_m      = {s2_sum_q[SIG_W:2], s2_sum_q[1] | s2_sum_q[0]};
      w_e_norm = {2'b00, s2_exp_q} + {{(EXP_W+1){1'b0}}, 1'b1};
    end else begin
      w_m      = s2_sum_q[SIG_W-1:0] << w_lzc;
      w_e_norm = {2'b00, s2_exp_q} - {{(EXP_W+2-LZC_W){1'b0}}, w_lzc};
    end
  end

  assign w_inexact = |w_m[2:0];
  assign w_rup     = w_m[2] && (w_m[1] || w_m[0] || w_m[3]);
  assign w_rnd     = {1'b0, w_m[SIG_W-1:3]} + {{(MAN_W+1){1'b0}}, w_rup};
  assign w_frac    = w_rnd[MAN_W+1] ? w_rnd[MAN_W:1] : w_rnd[MAN_W-1:0];
  assign w_e_rnd   = w_e_norm + {{(EXP_W+1){1'b0}}, w_rnd[MAN_W+1]};

  // A negative exponent shows up as the top bit of the two-bit headroom.
  always_comb begin
    c_d     = '0;
    flags_d = 4'b0000;
    if (s2_spec_q) begin
      c_d     = s2_spec_res_q;
      flags_d = s2_spec_flg_q;
    end else if (s2_sum_q == '0) begin
      c_d = {s2_negz_q, {(W-1){1'b0}}};
    end else if (!w_e_rnd[EXP_W+1] && (w_e_rnd >= {2'b00, {EXP_W{1'b1}}})) begin
      c_d     = {s2_sign_q, INF_MAG};
      flags_d = 4'b0101;
    end else if (w_e_rnd[EXP_W+1] || (w_e_rnd == '0)) begin
      c_d     = {s2_sign_q, {(W-1){1'b0}}};
      flags_d = 4'b0011;
    end else begin
      c_d     = {s2_sign_q, w_e_rnd[EXP_W-1:0], w_frac};
      flags_d = {3'b000, w_inexact};
    end
  end

  logic [W-1:0] c_q;
  logic [3:0]   flags_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_q <= 1'b0;
      c_q         <= '0;
      flags_q     <= '0;
    end else begin
      if (w_ready3) out_valid_q <= s2_valid_q;
      if (w_ready3 && s2_valid_q) begin
        c_q     <= c_d;
        flags_q <= flags_d;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign c         = c_q;
  assign flags     = flags_q;

endmodule

`default_nettype wire

// File: tb/tb_fp_addsub_pipe.sv
// ---- tb_fp_addsub_pipe : scoreboard bench for the pipelined FP add/sub unit ----
// ---- rev 1.0 ----
`timescale 1ns/1ps
`default_nettype none

module tb_fp_addsub_pipe;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic        op;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] c;
  logic [3:0]  flags;

  fp_addsub_pipe #(.EXP_W(8), .MAN_W(23)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .c         (c),
    .flags     (flags)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic        op;
    logic [31:0] c;
    logic [3:0]  f;
  } vec_t;

  typedef struct {
    logic [31:0] c;
    logic [3:0]  f;
    int          cyc;
  } exp_t;

  vec_t tbl [14];
  vec_t pend_q[$];
  exp_t scb_q[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;

  task automatic load_table();
    // flags = {invalid, overflow, underflow, inexact}
    tbl[0]  = {32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 4'b0000};
    tbl[1]  = {32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 4'b0000};
    tbl[2]  = {32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 4'b0000};
    tbl[3]  = {32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 4'b0001};
    tbl[4]  = {32'h3F800000, 32'h33C00000, 1'b0, 32'h3F800001, 4'b0001};
    tbl[5]  = {32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 4'b0101};
    tbl[6]  = {32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 4'b1000};
    tbl[7]  = {32'h40000000, 32'h3F800000, 1'b1, 32'h3F800000, 4'b0000};
    tbl[8]  = {32'h7FC00000, 32'h3F800000, 1'b0, 32'h7FC00000, 4'b0000};
    tbl[9]  = {32'h7F800001, 32'h3F800000, 1'b0, 32'h7FC00000, 4'b1000};
    tbl[10] = {32'h3F800000, 32'h7F800000, 1'b1, 32'hFF800000, 4'b0000};
    tbl[11] = {32'h00000001, 32'h00000000, 1'b0, 32'h00000000, 4'b0000};
    tbl[12] = {32'h00800000, 32'h00800001, 1'b1, 32'h80000000, 4'b0011};
    tbl[13] = {32'h3FC00000, 32'h3FC00000, 1'b0, 32'h40400000, 4'b0000};
  endtask

  // Drives pend_q into the unit and retires results against scb_q, one cycle per iteration.
  task automatic run_stream(input bit throttle, input int budget);
    logic [31:0] held_c;
    logic [3:0]  held_f;
    bit          stalled;
    logic        want_rdy;
    exp_t        e;
    int          n;
    stalled = 1'b0;
    held_c  = '0;
    held_f  = '0;
    n       = 0;
    while ((pend_q.size() != 0 || scb_q.size() != 0) && n < budget) begin
      @(negedge clk);
      out_ready = throttle ? (cyc % 3 == 0) : 1'b1;
      if (pend_q.size() != 0) begin
        in_valid = 1'b1;
        a        = pend_q[0].a;
        b        = pend_q[0].b;
        op       = pend_q[0].op;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      want_rdy = !(scb_q.size() == 3 && !out_ready);
      checks++;
      if (in_ready !== want_rdy) begin
        errors++;
        $display("FAIL in_ready cyc=%0d: got %b want %b (in flight %0d, out_ready %b)",
                 cyc, in_ready, want_rdy, scb_q.size(), out_ready);
      end
      if (stalled) begin
        checks++;
        if (out_valid !== 1'b1 || c !== held_c || flags !== held_f) begin
          errors++;
          $display("FAIL stall_hold cyc=%0d: got v=%b c=%h f=%b want v=1 c=%h f=%b",
                   cyc, out_valid, c, flags, held_c, held_f);
        end
      end
      stalled = (out_valid === 1'b1) && !out_ready;
      held_c  = c;
      held_f  = flags;
      if (out_valid === 1'b1 && out_ready) begin
        checks++;
        if (scb_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_output cyc=%0d: got c=%h f=%b want no result", cyc, c, flags);
        end else begin
          e = scb_q.pop_front();
          if (c !== e.c || flags !== e.f) begin
            errors++;
            $display("FAIL result cyc=%0d: got c=%h f=%b want c=%h f=%b", cyc, c, flags, e.c, e.f);
          end
          if (!throttle) begin
            checks++;
            if (cyc - e.cyc != 3) begin
              errors++;
              $display("FAIL latency cyc=%0d: got %0d cycles want 3", cyc, cyc - e.cyc);
            end
          end
        end
      end
      if (in_valid && in_ready === 1'b1) begin
        e.c   = pend_q[0].c;
        e.f   = pend_q[0].f;
        e.cyc = cyc;
        scb_q.push_back(e);
        void'(pend_q.pop_front());
      end
      cyc++;
      n++;
    end
    checks++;
    if (pend_q.size() != 0 || scb_q.size() != 0) begin
      errors++;
      $display("FAIL stream_timeout: got %0d pending/%0d outstanding want 0/0 after %0d cycles",
               pend_q.size(), scb_q.size(), budget);
      pend_q.delete();
      scb_q.delete();
    end
  endtask

  task automatic test_reset();
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    op        = 1'b0;
    a         = '0;
    b         = '0;
    repeat (2) @(negedge clk);
    checks += 3;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    if (c !== 32'h0)        begin errors++; $display("FAIL reset_c: got %h want 0", c); end
    if (flags !== 4'h0)     begin errors++; $display("FAIL reset_flags: got %b want 0", flags); end
    reset_n = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_add();
    pend_q.push_back(tbl[0]);
    pend_q.push_back(tbl[7]);
    pend_q.push_back(tbl[13]);
    run_stream(1'b0, 50);
  endtask

  task automatic test_zero();
    pend_q.push_back(tbl[1]);
    pend_q.push_back(tbl[2]);
    pend_q.push_back(tbl[11]);
    pend_q.push_back(tbl[12]);
    run_stream(1'b0, 50);
  endtask

  task automatic test_round();
    pend_q.push_back(tbl[3]);
    pend_q.push_back(tbl[4]);
    run_stream(1'b0, 50);
  endtask

  task automatic test_special();
    pend_q.push_back(tbl[5]);
    pend_q.push_back(tbl[6]);
    pend_q.push_back(tbl[8]);
    pend_q.push_back(tbl[9]);
    pend_q.push_back(tbl[10]);
    run_stream(1'b0, 50);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++) pend_q.push_back(tbl[i]);
    run_stream(1'b1, 200);
    for (int i = 0; i < 14; i++) pend_q.push_back(tbl[13 - i]);
    run_stream(1'b0, 100);
  endtask

  task automatic test_reset_midflight();
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a  = tbl[i].a;
      b  = tbl[i].b;
      op = tbl[i].op;
      @(negedge clk);
    end
    in_valid = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL midflight_full: got out_valid=%b want 1", out_valid); end
    #2;
    reset_n = 1'b0;
    #1;
    checks += 3;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL async_reset_valid: got %b want 0", out_valid); end
    if (c !== 32'h0)        begin errors++; $display("FAIL async_reset_c: got %h want 0", c); end
    if (flags !== 4'h0)     begin errors++; $display("FAIL async_reset_flags: got %b want 0", flags); end
    @(negedge clk);
    reset_n   = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL stale_output idle=%0d: got out_valid=%b c=%h want 0", i, out_valid, c);
      end
    end
    pend_q.push_back(tbl[7]);
    run_stream(1'b0, 50);
  endtask

  initial begin
    load_table();
    test_reset();
    test_add();
    test_zero();
    test_round();
    test_special();
    test_back_to_back();
    test_reset_midflight();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running want finished");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
